ram_req_bridge: RTL
===================

Name: ram_req_bridge

Overview:
- Initiator-side bridge driving a single-port byte-enabled RAM (1-cycle registered read; read port updates every cycle).
- Accepts core-style req/gnt requests, issues RAM accesses, captures read data on the following cycle, and returns responses through a buffered rvalid/rready channel with backpressure.
- Optionally zero-fills the RAM after reset before granting any request.
- Sits between an interconnect master port and the instruction/data RAM instance.

Parameters:
- ADDR_WIDTH, 8, byte-address width on both sides.
- DATA_WIDTH, 32, data width; multiple of 8.
- NUM_WORDS, 256, RAM size in bytes (RAM holds NUM_WORDS/(DATA_WIDTH/8) words).
- RSP_DEPTH, 2, response FIFO depth; power of two, >=2.
- CLEAR_ON_RESET, 1, 1 = run zero-fill after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- addr_i  in  ADDR_WIDTH  byte address
- we_i  in  1  1 = write
- be_i  in  DATA_WIDTH/8  byte enables
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid
- rready_i  in  1  response accepted
- rdata_o  out  DATA_WIDTH  read data; 0 for write responses
- rerr_o  out  1  response error flag
- init_done_o  out  1  zero-fill complete
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM byte address
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after access

Behaviour:
- Reset (rst_n=0 at posedge):
  - State := INIT if CLEAR_ON_RESET, else RUN; init counter, FIFO pointers/count and in-flight flag := 0.
  - Outputs during/after reset: gnt_o=0, rvalid_o=0, rerr_o=0, rdata_o=0, init_done_o=0 (1 if CLEAR_ON_RESET=0), ram_en_o=0.
- INIT state:
  - ram_en_o=1, ram_we_o=1, ram_be_o all ones, ram_wdata_o=0, ram_addr_o = init_cnt*(DATA_WIDTH/8).
  - One word per cycle; gnt_o=0.
  - After the last word (NUM_WORDS/(DATA_WIDTH/8)-1), next state RUN and init_done_o=1 (registered).
  - Reset mid-INIT restarts from word 0.
- RUN state, request path:
  - outstanding = fifo_count + inflight; pop = rvalid_o & rready_i.
  - gnt_o = req_i & ((outstanding < RSP_DEPTH) | pop). Combinational rready_i->gnt_o path is intentional.
  - On grant: ram_en_o=1; ram_addr_o/we/be/wdata pass through from inputs in the same cycle; inflight <= 1 with we and err tagged.
  - Without grant: ram_en_o=0, ram_we_o=0.
- Response capture:
  - The cycle after a grant, push {rdata = tag_we ? 0 : ram_rdata_i, err} into the FIFO.
  - Push and pop in the same cycle on a full FIFO are legal; count is unchanged.
- Response FIFO:
  - rvalid_o = count != 0; rdata_o/rerr_o from the head entry.
  - Head is held stable while rvalid_o & !rready_i.
  - No overflow is possible by construction; overflow is an assertion failure.
- Throughput and latency:
  - Sustains 1 request/cycle while rready_i is held high.
  - First rvalid_o is 2 cycles after a grant (1 RAM, 1 FIFO).
- Write byte enables pass through unchanged; be_i=0 is a legal no-op write and still responds.

Optional Feature:
- Macro: RAM_REQ_BRIDGE_ADDR_CHECK_EN.
- Defined:
  - A request with misaligned addr_i (low $clog2(DATA_WIDTH/8) bits != 0) or addr_i >= NUM_WORDS is still granted but ram_en_o=0.
  - Its response has rerr_o=1 and rdata_o=0, with the same latency as a normal access.
- Undefined: no check; rerr_o is tied to 0; low address bits are ignored by the RAM.

Decomposition:
- Package ram_bridge_pkg:
  - state enum {INIT, RUN}.
  - Function for BYTES = DATA_WIDTH/8 and OFFS_W = $clog2(BYTES).
  - Response entry struct typedef, parameterised through localparams.
- Sub-module ram_rsp_fifo: synchronous FIFO, parameters WIDTH and DEPTH, push/pop/full/empty/count.
- FSM, init counter and request path stay in ram_req_bridge.

Test Plan:
- Reset with CLEAR_ON_RESET=1, defaults -> 64 consecutive write cycles with addresses 0,4,...,252 and wdata 0; init_done_o rises on the cycle after the last write; gnt_o=0 throughout INIT.
- Write 0xDEADBEEF to addr 0x10, be=4'b0101, then read 0x10 -> write response rdata_o=0; read response rdata_o=0x00AD00EF.
- 8 back-to-back reads with rready_i=1 -> gnt_o high every cycle; 8 rvalid_o beats in order, first beat 2 cycles after the first grant.
- Hold rready_i=0 with req_i continuously high -> exactly RSP_DEPTH grants, then gnt_o=0; rdata_o stable; releasing rready_i resumes grants in the same cycle as the first pop.
- Assert rst_n=0 for 1 cycle mid-INIT at word 20 -> INIT restarts at addr 0; rvalid_o=0 and FIFO empty.
- With RAM_REQ_BRIDGE_ADDR_CHECK_EN: read addr 0x06 and addr 0x100 (ADDR_WIDTH=9) -> both granted, ram_en_o=0, responses rerr_o=1 and rdata_o=0; a subsequent read of 0x04 returns rerr_o=0.

Source files
------------

// File: rtl/ram_bridge_pkg.sv
// ram_bridge_pkg: shared state encoding, sizing helpers and response entry layout for ram_req_bridge
package ram_bridge_pkg;

    typedef enum logic {INIT, RUN} state_t;

    // Default data width; the response entry layout is sized from it.
    localparam int RSP_DW = 32;

    typedef struct packed {
        logic              err;
        logic [RSP_DW-1:0] rdata;
    } rsp_t;

    function automatic int bytes_of(input int dw);
        return dw / 8;
    endfunction

    function automatic int offs_w(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo: synchronous response FIFO, simultaneous push/pop allowed when full
// Ports: clk, rst_n (sync active-low); push/wdata write side; pop/rdata head side;
//        full, empty, count status.
module ram_rsp_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_V = DEPTH[PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) begin
                r_mem[r_wp] <= wdata;
                r_wp        <= r_wp + 1'b1;
            end
            if (pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign rdata = r_mem[r_rp];
    assign full  = (r_cnt == FULL_V);
    assign empty = (r_cnt == '0);
    assign count = r_cnt;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/ram_req_bridge.sv
// ram_req_bridge: req/gnt initiator bridge to a single-port byte-enabled RAM with buffered responses
// Optional macro RAM_REQ_BRIDGE_ADDR_CHECK_EN: misaligned or out-of-range requests are granted
// without touching the RAM and answer with rerr_o=1, rdata_o=0.
// Ports: clk, rst_n (sync active-low); req_i/gnt_o/addr_i/we_i/be_i/wdata_i request side;
//        rvalid_o/rready_i/rdata_o/rerr_o response side; init_done_o zero-fill done;
//        ram_en_o/ram_addr_o/ram_wdata_o/ram_we_o/ram_be_o/ram_rdata_i RAM port.
module ram_req_bridge import ram_bridge_pkg::*; #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = RSP_DW,
    parameter int NUM_WORDS      = 256,
    parameter int RSP_DEPTH      = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    rerr_o,
    output logic                    init_done_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BYTES   = bytes_of(DATA_WIDTH);
    localparam int OFFS_W  = offs_w(DATA_WIDTH);
    localparam int N_WORDS = NUM_WORDS / BYTES;
    localparam int CW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int QW      = $clog2(RSP_DEPTH) + 1;
    localparam logic [CW-1:0] LAST    = CW'(N_WORDS - 1);
    localparam logic [QW:0]   DEPTH_V = RSP_DEPTH[QW:0];

    state_t                r_state;
    logic [CW-1:0]         r_init_cnt;
    logic                  r_init_done;
    logic                  r_inflight;
    logic                  r_tag_we;
    logic                  r_tag_err;

    logic                  w_init_wr;
    logic                  w_run;
    logic                  w_pop;
    logic                  w_gnt;
    logic                  w_err;
    logic                  w_full;
    logic                  w_empty;
    logic [QW-1:0]         w_count;
    logic [QW:0]           w_outstanding;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    rsp_t                  w_push_d;
    rsp_t                  w_head;

`ifdef RAM_REQ_BRIDGE_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] LIMIT = NUM_WORDS[ADDR_WIDTH:0];
    assign w_err = (addr_i[OFFS_W-1:0] != '0) | ({1'b0, addr_i} >= LIMIT);
`else
    assign w_err = 1'b0;
`endif

    // Gating with rst_n keeps the RAM and request ports quiet while reset is asserted.
    assign w_init_wr     = rst_n & (r_state == INIT);
    assign w_run         = rst_n & (r_state == RUN);
    assign w_pop         = rvalid_o & rready_i;
    assign w_outstanding = {1'b0, w_count} + {{QW{1'b0}}, r_inflight};
    // A pop in the same cycle frees a slot, so rready_i feeds gnt_o combinationally.
    assign w_gnt         = w_run & req_i & ((!w_full & (w_outstanding < DEPTH_V)) | w_pop);
    assign w_init_addr   = ADDR_WIDTH'({r_init_cnt, {OFFS_W{1'b0}}});

    assign gnt_o       = w_gnt;
    assign ram_en_o    = w_init_wr | (w_gnt & !w_err);
    assign ram_we_o    = w_init_wr | (w_gnt & !w_err & we_i);
    assign ram_be_o    = w_init_wr ? '1 : be_i;
    assign ram_wdata_o = w_init_wr ? '0 : wdata_i;
    assign ram_addr_o  = w_init_wr ? w_init_addr : addr_i;
    assign init_done_o = r_init_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            r_init_cnt  <= '0;
            r_init_done <= (CLEAR_ON_RESET == 0);
            r_inflight  <= 1'b0;
            r_tag_we    <= 1'b0;
            r_tag_err   <= 1'b0;
        end else begin
            if (r_state == INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
                if (r_init_cnt == LAST) begin
                    r_state     <= RUN;
                    r_init_done <= 1'b1;
                end
            end
            r_inflight <= w_gnt;
            if (w_gnt) begin
                r_tag_we  <= we_i;
                r_tag_err <= w_err;
            end
        end
    end

    // Write and rejected responses carry zero data regardless of what the RAM read port shows.
    always_comb begin
        w_push_d       = '0;
        w_push_d.err   = r_tag_err;
        w_push_d.rdata = (r_tag_we | r_tag_err) ? '0 : ram_rdata_i;
    end

    ram_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .wdata (w_push_d),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign rvalid_o = !w_empty;
    assign rdata_o  = rvalid_o ? w_head.rdata : '0;
    assign rerr_o   = rvalid_o & w_head.err;

endmodule
